// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one data memory between the CPU load/store port (port 0) and the
// DMA/debug loader port (port 1). At most one access is granted per cycle.
// Contention is resolved round-robin. The port that won last may keep the
// grant while it asserts its lock, for at most MAX_HOLD consecutive grants.
// The memory's combinational read data is registered, so each port sees its
// load data one cycle after the grant. Word accesses whose address is not
// 4-byte aligned are rejected with an error pulse and never touch memory.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req/we/lock 0,1     request, store(1)/load(0), keep-grant request
//   addr/wdata 0,1      byte address and store data per port
//   gnt 0,1             combinational grant (one-hot or zero)
//   rvalid/rdata 0,1    registered load completion and data (data held)
//   err 0,1             registered misaligned-access error pulse
//   mem_we/addr/wdata   memory drive, taken from the winning port
//   mem_rdata           combinational read data from the memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    localparam logic [3:0] MAX_HOLD_L = 4'(MAX_HOLD);

    port_e             last_q, last_d;
    port_e             winner;
    logic [3:0]        holdCnt_q, holdCnt_d;
    logic              anyGrant;
    logic              lastLocked;
    logic              aligned0, aligned1;
    logic              rvalid0_q, rvalid1_q, rvalid0_d, rvalid1_d;
    logic              err0_q, err1_q, err0_d, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    // Arbitration. A lone requester always wins. Under contention the last
    // winner keeps the grant only while its lock is up and it has not yet
    // used up its hold budget; otherwise the other port gets its turn.
    // Nothing is granted while reset is asserted.
    always_comb begin
        anyGrant   = 1'b0;
        winner     = PORT0;
        lastLocked = ((last_q == PORT1) ? lock1 : lock0) && (holdCnt_q < MAX_HOLD_L);
        if (rst_n) begin
            if (req0 && !req1) begin
                anyGrant = 1'b1;
                winner   = PORT0;
            end else if (req1 && !req0) begin
                anyGrant = 1'b1;
                winner   = PORT1;
            end else if (req0 && req1) begin
                anyGrant = 1'b1;
                winner   = lastLocked ? last_q : ((last_q == PORT0) ? PORT1 : PORT0);
            end
        end
    end

    assign gnt0 = anyGrant && (winner == PORT0);
    assign gnt1 = anyGrant && (winner == PORT1);

    // Every grant, contended or not, feeds the hold counter so a lock
    // always starts from an accurate count of consecutive wins.
    always_comb begin
        last_d    = last_q;
        holdCnt_d = holdCnt_q;
        if (anyGrant) begin
            if (winner == last_q) begin
                if (holdCnt_q != 4'hF) begin
                    holdCnt_d = holdCnt_q + 4'd1;
                end
            end else begin
                holdCnt_d = 4'd1;
                last_d    = winner;
            end
        end
    end

    // The memory bus follows the winner and idles on port 0's values.
    // A misaligned store is suppressed here so it can never corrupt memory.
    assign mem_addr  = gnt1 ? addr1 : addr0;
    assign mem_wdata = gnt1 ? wdata1 : wdata0;
    assign mem_we    = anyGrant && (gnt1 ? we1 : we0) && (mem_addr[1:0] == 2'b00);

    assign aligned0  = (addr0[1:0] == 2'b00);
    assign aligned1  = (addr1[1:0] == 2'b00);
    assign rvalid0_d = gnt0 && !we0 && aligned0;
    assign rvalid1_d = gnt1 && !we1 && aligned1;
    assign err0_d    = gnt0 && !aligned0;
    assign err1_d    = gnt1 && !aligned1;

    // Arbiter state and completion registers. Load data is captured only
    // on a successful load, so rdata holds its value across stores, errors
    // and idle cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q    <= PORT1;
            holdCnt_q <= 4'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            last_q    <= last_d;
            holdCnt_q <= holdCnt_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            if (rvalid0_d) begin
                rdata0_q <= mem_rdata;
            end
            if (rvalid1_d) begin
                rdata1_q <= mem_rdata;
            end
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Drives dmem_arbiter against a small word-addressed RAM. A table of directed
// vectors walks the key scenarios with hand-derived expectations, then random
// traffic is compared with a behavioural model of the arbitration rules and
// of the memory contents. A closing sequence checks round-robin restart after
// reset.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct packed {
        logic        rstn, req0, req1, we0, we1, lock0, lock1;
        logic [31:0] addr0, addr1, wd0, wd1;
    } in_t;

    typedef struct packed {
        logic        gnt0, gnt1, memWe;
        logic [31:0] memAddr, memWdata;
        logic        rv0, rv1, err0, err1;
        logic [31:0] rd0, rd1;
    } exp_t;

    typedef struct packed {
        in_t  stim;
        exp_t want;
    } vec_t;

    logic [31:0] ram    [0:127];
    logic [31:0] refMem [0:127];
    logic [31:0] mRd    [2];
    int          mLast;
    int          mHold;
    exp_t        act;
    exp_t        mExp;
    int          vectors     = 0;
    int          miscompares = 0;
    vec_t        table_v [19];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .err0      (err0),
        .err1      (err1),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory seen by the arbiter: combinational read, write on the clock.
    assign mem_rdata = ram[mem_addr[8:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[8:2]] <= mem_wdata;
        end
    end

    // One cycle: drive inputs mid-cycle, let the model predict, sample the
    // combinational outputs before the edge and the registered ones after it.
    task automatic applyStimulus(input in_t s);
        logic        rq [2];
        logic        wv [2];
        logic        lk [2];
        logic [31:0] ad [2];
        logic [31:0] wdv[2];
        logic        rvA[2];
        logic        erA[2];
        int          w;
        int          sel;
        @(negedge clk);
        rst_n  = s.rstn;
        req0   = s.req0;   req1   = s.req1;
        we0    = s.we0;    we1    = s.we1;
        lock0  = s.lock0;  lock1  = s.lock1;
        addr0  = s.addr0;  addr1  = s.addr1;
        wdata0 = s.wd0;    wdata1 = s.wd1;
        #2;
        rq[0] = s.req0;  rq[1] = s.req1;
        wv[0] = s.we0;   wv[1] = s.we1;
        lk[0] = s.lock0; lk[1] = s.lock1;
        ad[0] = s.addr0; ad[1] = s.addr1;
        wdv[0] = s.wd0;  wdv[1] = s.wd1;
        rvA[0] = 1'b0; rvA[1] = 1'b0;
        erA[0] = 1'b0; erA[1] = 1'b0;
        w = -1;
        if (s.rstn) begin
            if (rq[0] && rq[1]) begin
                w = (lk[mLast] && (mHold < MAX_HOLD)) ? mLast : 1 - mLast;
            end else if (rq[0]) begin
                w = 0;
            end else if (rq[1]) begin
                w = 1;
            end
        end
        sel = (w == 1) ? 1 : 0;
        mExp.gnt0     = (w == 0);
        mExp.gnt1     = (w == 1);
        mExp.memAddr  = ad[sel];
        mExp.memWdata = wdv[sel];
        mExp.memWe    = (w >= 0) && wv[sel] && (ad[sel][1:0] == 2'b00);
        if (!s.rstn) begin
            mLast  = 1;
            mHold  = 0;
            mRd[0] = 32'h0;
            mRd[1] = 32'h0;
        end else if (w >= 0) begin
            if (ad[w][1:0] != 2'b00) begin
                erA[w] = 1'b1;
            end else if (!wv[w]) begin
                rvA[w] = 1'b1;
                mRd[w] = refMem[ad[w][8:2]];
            end else begin
                refMem[ad[w][8:2]] = wdv[w];
            end
            if (w == mLast) begin
                mHold = (mHold < 15) ? mHold + 1 : 15;
            end else begin
                mHold = 1;
                mLast = w;
            end
        end
        mExp.rv0  = rvA[0];
        mExp.rv1  = rvA[1];
        mExp.err0 = erA[0];
        mExp.err1 = erA[1];
        mExp.rd0  = mRd[0];
        mExp.rd1  = mRd[1];
        act.gnt0     = gnt0;
        act.gnt1     = gnt1;
        act.memWe    = mem_we;
        act.memAddr  = mem_addr;
        act.memWdata = mem_wdata;
        @(posedge clk);
        #1;
        act.rv0  = rvalid0;
        act.rv1  = rvalid1;
        act.err0 = err0;
        act.err1 = err1;
        act.rd0  = rdata0;
        act.rd1  = rdata1;
    endtask

    task automatic cmpField(input string tag, input string name,
                            input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s %s: got 0x%08h expected 0x%08h", tag, name, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        vectors++;
        cmpField(tag, "gnt0",      32'(act.gnt0),  32'(e.gnt0));
        cmpField(tag, "gnt1",      32'(act.gnt1),  32'(e.gnt1));
        cmpField(tag, "mem_we",    32'(act.memWe), 32'(e.memWe));
        cmpField(tag, "mem_addr",  act.memAddr,    e.memAddr);
        cmpField(tag, "mem_wdata", act.memWdata,   e.memWdata);
        cmpField(tag, "rvalid0",   32'(act.rv0),   32'(e.rv0));
        cmpField(tag, "rvalid1",   32'(act.rv1),   32'(e.rv1));
        cmpField(tag, "err0",      32'(act.err0),  32'(e.err0));
        cmpField(tag, "err1",      32'(act.err1),  32'(e.err1));
        cmpField(tag, "rdata0",    act.rd0,        e.rd0);
        cmpField(tag, "rdata1",    act.rd1,        e.rd1);
    endtask

    initial begin
        in_t s;
        for (int i = 0; i < 128; i++) begin
            ram[i]    = 32'h1000_0000 + 32'(i);
            refMem[i] = 32'h1000_0000 + 32'(i);
        end
        ram[4]    = 32'hDEAD_BEEF;
        refMem[4] = 32'hDEAD_BEEF;
        mRd[0] = 32'h0;
        mRd[1] = 32'h0;
        mLast  = 1;
        mHold  = 0;
        rst_n  = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;

        // Reset while both ports try to store: nothing granted or written.
        table_v[0]  = '{'{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,32'h40,32'h44,32'h11,32'h22},
                        '{1'b0,1'b0,1'b0,32'h40,32'h11,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0}};
        // Port 0 load 0x10 reads RAM[4].
        table_v[1]  = '{'{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h10,32'h0,32'h0,32'h0},
                        '{1'b1,1'b0,1'b0,32'h10,32'h0,1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF,32'h0}};
        // Both loading, no lock: grants alternate.
        table_v[2]  = '{'{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h20,32'h24,32'h0,32'h0},
                        '{1'b0,1'b1,1'b0,32'h24,32'h0,1'b0,1'b1,1'b0,1'b0,32'hDEADBEEF,32'h10000009}};
        table_v[3]  = '{'{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h20,32'h24,32'h0,32'h0},
                        '{1'b1,1'b0,1'b0,32'h20,32'h0,1'b1,1'b0,1'b0,1'b0,32'h10000008,32'h10000009}};
        table_v[4]  = '{'{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h20,32'h24,32'h0,32'h0},
                        '{1'b0,1'b1,1'b0,32'h24,32'h0,1'b0,1'b1,1'b0,1'b0,32'h10000008,32'h10000009}};
        // Port 1 locks: it holds for MAX_HOLD grants, yields one, resumes.
        table_v[5]  = '{'{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,32'h20,32'h24,32'h0,32'h0},
                        '{1'b0,1'b1,1'b0,32'h24,32'h0,1'b0,1'b1,1'b0,1'b0,32'h10000008,32'h10000009}};
        table_v[6]  = table_v[5];
        table_v[7]  = table_v[5];
        table_v[8]  = '{'{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,32'h20,32'h24,32'h0,32'h0},
                        '{1'b1,1'b0,1'b0,32'h20,32'h0,1'b1,1'b0,1'b0,1'b0,32'h10000008,32'h10000009}};
        table_v[9]  = table_v[5];
        // Misaligned store from port 1 errors and does not write.
        table_v[10] = '{'{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,32'h22,32'h0,32'h1234},
                        '{1'b0,1'b1,1'b0,32'h22,32'h1234,1'b0,1'b0,1'b0,1'b1,32'h10000008,32'h10000009}};
        table_v[11] = '{'{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h20,32'h0,32'h0,32'h0},
                        '{1'b1,1'b0,1'b0,32'h20,32'h0,1'b1,1'b0,1'b0,1'b0,32'h10000008,32'h10000009}};
        // Aligned store to 0x20 then readback.
        table_v[12] = '{'{1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,32'h20,32'h0,32'h1234},
                        '{1'b0,1'b1,1'b1,32'h20,32'h1234,1'b0,1'b0,1'b0,1'b0,32'h10000008,32'h10000009}};
        table_v[13] = '{'{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,32'h20,32'h0,32'h0,32'h0},
                        '{1'b1,1'b0,1'b0,32'h20,32'h0,1'b1,1'b0,1'b0,1'b0,32'h1234,32'h10000009}};
        // Port 0 store followed by port 1 load of the same word.
        table_v[14] = '{'{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h20,32'h0,32'hA5A5A5A5,32'h0},
                        '{1'b1,1'b0,1'b1,32'h20,32'hA5A5A5A5,1'b0,1'b0,1'b0,1'b0,32'h1234,32'h10000009}};
        table_v[15] = '{'{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,32'h20,32'h0,32'h0},
                        '{1'b0,1'b1,1'b0,32'h20,32'h0,1'b0,1'b1,1'b0,1'b0,32'h1234,32'hA5A5A5A5}};
        // Reset during a store attempt, then contention restarts on port 0.
        table_v[16] = '{'{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h40,32'h0,32'hBAD00001,32'h0},
                        '{1'b0,1'b0,1'b0,32'h40,32'hBAD00001,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0}};
        table_v[17] = '{'{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h40,32'h44,32'h0,32'h0},
                        '{1'b1,1'b0,1'b0,32'h40,32'h0,1'b1,1'b0,1'b0,1'b0,32'h10000010,32'h0}};
        table_v[18] = '{'{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h40,32'h44,32'h0,32'h0},
                        '{1'b0,1'b1,1'b0,32'h44,32'h0,1'b0,1'b1,1'b0,1'b0,32'h10000010,32'h10000011}};

        $display("[TB] directed vectors");
        for (int i = 0; i < 19; i++) begin
            applyStimulus(table_v[i].stim);
            checkOutput($sformatf("vec%0d", i), table_v[i].want);
        end

        $display("[TB] random traffic against model");
        for (int n = 0; n < 500; n++) begin
            s.rstn  = ($urandom_range(0, 31) != 0);
            s.req0  = 1'($urandom_range(0, 1));
            s.req1  = 1'($urandom_range(0, 1));
            s.we0   = 1'($urandom_range(0, 1));
            s.we1   = 1'($urandom_range(0, 1));
            s.lock0 = 1'($urandom_range(0, 1));
            s.lock1 = 1'($urandom_range(0, 1));
            s.addr0 = 32'($urandom_range(0, 511));
            s.addr1 = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) s.addr0[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) s.addr1[1:0] = 2'b00;
            s.wd0   = $urandom;
            s.wd1   = $urandom;
            applyStimulus(s);
            checkOutput($sformatf("rand%0d", n), mExp);
        end

        $display("[TB] round-robin restart after reset");
        s = '0;
        s.addr0 = 32'h8;
        s.addr1 = 32'hC;
        applyStimulus(s);
        s.rstn = 1'b1;
        s.req0 = 1'b1;
        s.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(s);
            vectors++;
            cmpField($sformatf("rr%0d", k), "gnt0", 32'(act.gnt0), ((k % 2) == 0) ? 32'd1 : 32'd0);
            cmpField($sformatf("rr%0d", k), "gnt1", 32'(act.gnt1), ((k % 2) == 1) ? 32'd1 : 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter that shares the single data memory between the CPU load/store port (port 0) and a DMA/debug loader port (port 1).
- Grants at most one access per cycle using round-robin with an optional bounded lock, and drives the memory's write enable, address and write data.
- Registers the memory's combinational read data, so requesters see a one-cycle read latency.
- Rejects misaligned word accesses.

Parameters:
- ADDR_W, 32, width of requester and memory addresses.
- DATA_W, 32, data width.
- MAX_HOLD, 4, maximum consecutive grants to a locked port while the other port is requesting (range 1-15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0 / req1  in  1  access request, held until granted.
- we0 / we1  in  1  1 = store, 0 = load; valid with req.
- lock0 / lock1  in  1  requester asks to keep the grant next cycle.
- addr0 / addr1  in  ADDR_W  byte address; must be word-aligned.
- wdata0 / wdata1  in  DATA_W  store data.
- gnt0 / gnt1  out  1  combinational grant for the current cycle; one-hot or zero.
- rvalid0 / rvalid1  out  1  registered; pulses one cycle after a granted load.
- rdata0 / rdata1  out  DATA_W  registered load data; held until the next load completes on that port.
- err0 / err1  out  1  registered; pulses one cycle after a granted misaligned access.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address; the memory indexes bits [8:2].
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  combinational read data from memory.

Behaviour:
- State:
  - last: the most recent winner.
  - hold_cnt: 4 bits, consecutive grants to the same port.
- Reset, while rst_n is low at an edge:
  - last=1, so port 0 wins the first contention.
  - hold_cnt=0.
  - rvalid*, err* = 0; rdata* = 0.
  - gnt* and mem_we are forced 0 combinationally during any cycle in which rst_n is low.
- Arbitration, combinational each cycle:
  - Only one port requesting: that port wins.
  - Both requesting, locked port: if the port that won last has its lock asserted and hold_cnt < MAX_HOLD, it wins again.
  - Both requesting, otherwise: the port that is not last wins.
  - No requests: no grant; last and hold_cnt are unchanged.
- Counter update on a grant:
  - Winner equals last: hold_cnt increments, saturating at 15.
  - Winner differs from last: hold_cnt=1 and last=winner.
  - Uncontended grants also update last and hold_cnt; the MAX_HOLD limit applies only when the other port is requesting.
- Memory drive:
  - mem_addr and mem_wdata are muxed from the winner; with no grant they carry port 0's values.
  - mem_we = winner's we AND aligned, where aligned means addr[1:0]==0.
  - Misaligned stores never write memory.
- Load completion, granted load, aligned:
  - At the edge ending the grant cycle, rdata_k <= mem_rdata.
  - rvalid_k=1 for exactly the next cycle.
  - Store grants do not assert rvalid.
- Error completion, granted access, misaligned:
  - err_k=1 for the next cycle.
  - rvalid_k stays 0 and rdata_k is unchanged.
- Back-to-back grants to one port give back-to-back rvalid pulses.
- A load and a store to the same address in successive cycles return the pre-store value for the load if it is granted first. No forwarding inside the arbiter.
- Requester protocol:
  - Hold req, we, addr, wdata stable until the gnt cycle; deassert or present a new request the following cycle.
  - A req without gnt has no side effect.
- Reset mid-operation:
  - A grant in the cycle reset is sampled does not write memory.
  - A pending rvalid/err is cleared.
  - Arbitration restarts with port 0 preferred.

Test Plan:
- Reset, then req0 load addr 0x10 while RAM[4]=0xDEADBEEF → gnt0 in the same cycle, rvalid0=1 and rdata0=0xDEADBEEF next cycle; gnt1=0.
- req0 and req1 held continuously, no lock → grants alternate 0,1,0,1 starting with 0; each port's rvalid follows its grant by one cycle.
- lock1=1 with both requesting, MAX_HOLD=4 → port 1 wins 4 consecutive cycles, then port 0 wins one cycle, then port 1 resumes.
- req1 store addr 0x22, wdata 0x1234 → gnt1, mem_we=0, err1=1 next cycle, RAM unchanged. A following aligned store to 0x20 writes RAM[8]=0x1234.
- Port 0 store 0x20 ← 0xA5A5A5A5 in cycle N, port 1 load 0x20 in N+1 → rdata1=0xA5A5A5A5 in N+2.
- rst_n low in the same cycle as a granted store → no memory write, rvalid/err=0 after reset, and the first contended grant afterwards goes to port 0.
